// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch front end. It owns the PC, resolves redirect
//             targets, and buffers synchronous-memory responses for decode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             redir_valid,
    input  logic [1:0]       redir_mode,
    input  logic [WIDTH-1:0] redir_pc,
    input  logic [25:0]      redir_imm,
    input  logic [WIDTH-1:0] redir_reg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic [WIDTH-1:0] out_pc,
    output logic [WIDTH-1:0] out_pc4
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W:0] c_DEPTH = DEPTH[c_CNT_W:0];
    localparam logic [WIDTH-1:0] c_FOUR  = WIDTH'(4);

    logic [WIDTH-1:0]   r_fetch_pc;
    logic               r_inflight;
    logic [WIDTH-1:0]   r_tag;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_buf_inst [DEPTH];
    logic [WIDTH-1:0]   r_buf_pc   [DEPTH];

    logic               w_nonempty;
    logic               w_pop;
    logic               w_push;
    logic [c_CNT_W:0]   w_occ;
    logic [WIDTH-1:0]   w_pc4;
    logic [WIDTH-1:0]   w_target;

    assign w_nonempty = (r_count != '0);
    assign out_valid  = w_nonempty && !redir_valid;
    assign w_pop      = out_valid && out_ready;
    assign w_push     = r_inflight && !redir_valid;
    assign w_occ      = {1'b0, r_count} + {{c_CNT_W{1'b0}}, r_inflight};

    // A slot freed by this cycle's pop can be refilled by the response to
    // this cycle's request, so a full pipeline keeps streaming.
    assign imem_req  = !rst && !redir_valid &&
                       ((w_occ < c_DEPTH) || ((w_occ == c_DEPTH) && w_pop));
    assign imem_addr = r_fetch_pc;

    assign out_inst = w_nonempty ? r_buf_inst[r_rd_ptr] : 32'd0;
    assign out_pc   = w_nonempty ? r_buf_pc[r_rd_ptr] : '0;
    assign out_pc4  = w_nonempty ? (r_buf_pc[r_rd_ptr] + c_FOUR) : '0;

    assign w_pc4 = redir_pc + c_FOUR;

    always_comb begin
        w_target = w_pc4;
        case (redir_mode)
            2'b00:   w_target = {w_pc4[WIDTH-1:28], redir_imm, 2'b00};
            2'b01:   w_target = w_pc4 + {{(WIDTH-18){redir_imm[15]}}, redir_imm[15:0], 2'b00};
            2'b10:   w_target = redir_reg & {{(WIDTH-2){1'b1}}, 2'b00};
            default: w_target = w_pc4;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 1'b0;
            r_tag      <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redir_valid) begin
            // Redirect wins over everything: drop buffered and in-flight work.
            r_fetch_pc <= w_target;
            r_inflight <= 1'b0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_tag      <= r_fetch_pc;
                r_fetch_pc <= r_fetch_pc + c_FOUR;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_buf_inst[r_wr_ptr] <= imem_rdata;
            r_buf_pc[r_wr_ptr]   <= r_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Self-checking bench for fetch_unit against a queue-based model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [1:0]  redir_mode;
    logic [31:0] redir_pc;
    logic [25:0] redir_imm;
    logic [31:0] redir_reg;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc4;

    fetch_unit #(.WIDTH(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redir_valid (redir_valid),
        .redir_mode  (redir_mode),
        .redir_pc    (redir_pc),
        .redir_imm   (redir_imm),
        .redir_reg   (redir_reg),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc4     (out_pc4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // Synchronous instruction memory: data for the address requested last cycle.
    initial imem_rdata = 32'd0;
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= memf(imem_addr);
    end

    // Reference model: fetch PC, one outstanding tag, queue of {inst, pc}.
    logic [31:0] m_pc;
    logic        m_inflight;
    logic [31:0] m_tag;
    logic [63:0] m_q [$];
    logic        e_req;
    logic        e_pop;

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [31:0] target(input logic [1:0] mode, input logic [31:0] pc,
                                           input logic [25:0] imm, input logic [31:0] rg);
        logic [31:0] pc4;
        logic signed [31:0] off;
        pc4 = pc + 32'd4;
        off = 32'($signed(imm[15:0])) * 4;
        case (mode)
            2'd0:    return (pc4 & 32'hF000_0000) | ({6'd0, imm} * 4);
            2'd1:    return pc4 + 32'(off);
            2'd2:    return rg & ~32'd3;
            default: return pc4;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_inflight = 1'b0;
        m_tag = 32'h0;
        m_q.delete();
    endtask

    task automatic compare_model();
        int occ;
        logic        ev;
        logic [63:0] head;
        occ   = m_q.size() + int'(m_inflight);
        ev    = (m_q.size() != 0) && !redir_valid;
        e_pop = ev && out_ready;
        e_req = !rst && !redir_valid && (occ < DEPTH || (occ == DEPTH && e_pop));
        head  = (m_q.size() != 0) ? m_q[0] : 64'd0;
        chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
        chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
        chk("imem_addr", imem_addr, m_pc);
        chk("out_inst", out_inst, head[63:32]);
        chk("out_pc", out_pc, head[31:0]);
        chk("out_pc4", out_pc4, (m_q.size() != 0) ? head[31:0] + 32'd4 : 32'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        if (redir_valid) begin
            m_q.delete();
            m_inflight = 1'b0;
            m_pc = target(redir_mode, redir_pc, redir_imm, redir_reg);
        end else begin
            if (e_pop) void'(m_q.pop_front());
            if (m_inflight) m_q.push_back({memf(m_tag), m_tag});
            m_inflight = e_req;
            if (e_req) begin
                m_tag = m_pc;
                m_pc  = m_pc + 32'd4;
            end
        end
        if (m_q.size() > DEPTH) chk("model_overflow", m_q.size(), DEPTH);
    endtask

    task automatic drive(input logic rdy, input logic rv, input logic [1:0] md,
                         input logic [31:0] rpc, input logic [25:0] imm, input logic [31:0] rg);
        @(negedge clk);
        out_ready   = rdy;
        redir_valid = rv;
        redir_mode  = md;
        redir_pc    = rpc;
        redir_imm   = imm;
        redir_reg   = rg;
        #1 compare_model();
    endtask

    task automatic idle(input logic rdy);
        drive(rdy, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        tick();
    endtask

    // Redirect in cycle T, then check the target reaches decode at T+3.
    task automatic redirect_check(input string name, input logic [1:0] md, input logic [31:0] rpc,
                                  input logic [25:0] imm, input logic [31:0] rg,
                                  input logic [31:0] exp_tgt);
        drive(1'b1, 1'b1, md, rpc, imm, rg);
        chk({name, "_valid_T"}, {31'd0, out_valid}, 32'd0);
        tick();
        idle(1'b1);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk({name, "_valid_T2"}, {31'd0, out_valid}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk({name, "_valid_T3"}, {31'd0, out_valid}, 32'd1);
        chk({name, "_pc_T3"}, out_pc, exp_tgt);
        chk({name, "_inst_T3"}, out_inst, memf(exp_tgt));
        tick();
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        out_ready = 1'b1;
        redir_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_async_req", {31'd0, imem_req}, 32'd0);
        rst = 1'b0;
        model_reset();
        #1 compare_model();
        chk("rst_restart_addr", imem_addr, 32'h0);
        tick();
    endtask

    initial begin
        rst = 1'b1;
        out_ready = 1'b1;
        redir_valid = 1'b0;
        redir_mode = 2'd0;
        redir_pc = 32'd0;
        redir_imm = 26'd0;
        redir_reg = 32'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_pc", out_pc, 32'd0);

        // Start-up: request in cycle 0, first instruction valid in cycle 2.
        @(negedge clk);
        rst = 1'b0;
        #1 compare_model();
        chk("start_req_c0", {31'd0, imem_req}, 32'd1);
        tick();
        idle(1'b1);
        drive(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk("start_valid_c2", {31'd0, out_valid}, 32'd1);
        chk("start_pc_c2", out_pc, 32'h0);
        chk("start_pc4_c2", out_pc4, 32'h4);
        tick();
        drive(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk("stream_pc_c3", out_pc, 32'h4);
        tick();
        repeat (5) idle(1'b1);

        // Backpressure: buffer fills, requests stop, then drain without gaps.
        repeat (10) idle(1'b0);
        drive(1'b0, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
        chk("stall_req_off", {31'd0, imem_req}, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 2'd0, 32'd0, 26'd0, 32'd0);
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            tick();
        end

        redirect_check("branch", 2'd1, 32'h0000_0100, 26'h000FFFC, 32'd0, 32'h0000_00F4);
        repeat (3) idle(1'b1);
        redirect_check("jump", 2'd0, 32'h3000_0010, 26'h0000040, 32'd0, 32'h3000_0100);
        redirect_check("jreg", 2'd2, 32'h0000_0000, 26'd0, 32'h0000_0203, 32'h0000_0200);
        redirect_check("wrap", 2'd2, 32'd0, 26'd0, 32'hFFFF_FFF8, 32'hFFFF_FFF8);
        repeat (4) idle(1'b1);

        // Back-to-back redirects: only the last one takes effect.
        drive(1'b1, 1'b1, 2'd3, 32'h0000_1000, 26'd0, 32'd0);
        tick();
        redirect_check("b2b", 2'd3, 32'h0000_2000, 26'd0, 32'd0, 32'h0000_2004);

        rst_pulse();
        repeat (4) idle(1'b1);

        // Randomised traffic with occasional redirects and reset pulses.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                rst_pulse();
            end else begin
                drive($urandom_range(0, 9) < 7,
                      $urandom_range(0, 19) == 0,
                      2'($urandom_range(0, 3)),
                      ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & ~32'd3),
                      26'($urandom()),
                      $urandom());
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the MIPS cores.
- Owns the program counter and computes jump, branch and jalr targets internally.
- Issues requests to a synchronous instruction memory and buffers returned instructions in a DEPTH-entry FIFO.
- Hands each instruction, with its PC and PC+4, to decode over a valid/ready handshake; a redirect flushes all fetched and in-flight instructions.

Parameters:
WIDTH, 32, address/PC width; must be >= 32
DEPTH, 4, instruction buffer entries; power of two, >= 2
RESET_PC, 0, PC loaded on reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
imem_req  output  1  fetch request this cycle
imem_addr  output  WIDTH  fetch address (= fetch_pc)
imem_rdata  input  32  instruction; valid the cycle after an accepted request
redir_valid  input  1  redirect request
redir_mode  input  2  00 jump, 01 branch, 10 register, 11 sequential restart
redir_pc  input  WIDTH  PC of the redirecting instruction
redir_imm  input  26  jump index, or branch offset in [15:0]
redir_reg  input  WIDTH  register target for jalr/jr
out_valid  output  1  buffer head is valid
out_ready  input  1  decode accepts the head
out_inst  output  32  head instruction
out_pc  output  WIDTH  head PC
out_pc4  output  WIDTH  head PC+4, used as the link value

Behaviour:
- Reset (async, rst=1): fetch_pc=RESET_PC, buffer empty, inflight=0, out_valid=0, imem_req=0. out_inst, out_pc and out_pc4 read 0 while the buffer is empty.
- imem_req=1 iff redir_valid=0 and (count+inflight < DEPTH, or count+inflight == DEPTH with a pop this cycle). Rst asserted also forces imem_req=0.
- Request accepted at the edge where imem_req=1:
  - fetch_pc += 4, modulo 2^WIDTH.
  - inflight <= 1 and the request address is saved as the tag.
- When inflight=1:
  - imem_rdata and the tag are written to the buffer tail at the next edge.
  - inflight clears unless a new request is accepted at the same edge.
- Pop: out_valid && out_ready at an edge.
- out_valid = (count != 0) && !redir_valid, so no pop can occur in a redirect cycle.
- Push and pop at the same edge are both honoured. count never exceeds DEPTH; the request gating guarantees no overflow.
- With out_ready held high and no redirect, throughput is 1 instruction per cycle.
- Redirect target, with pc4 = redir_pc + 4:
  - 00: {pc4[WIDTH-1:28], redir_imm, 2'b00}
  - 01: pc4 + (sign_extend(redir_imm[15:0]) << 2)
  - 10: redir_reg with bits [1:0] forced to 0
  - 11: pc4
- Redirect edge (redir_valid=1):
  - fetch_pc <= target.
  - Buffer emptied; count=0.
  - Any in-flight response is discarded and never written.
  - redir_valid has priority over every push and pop at that edge.
- Redirect latency: with the redirect in cycle T, the request for the target issues in T+1, data returns in T+2, and out_valid=1 with out_pc=target in T+3.
- Start-up: after reset release, the first request is in cycle 0 and out_valid=1 in cycle 2 with out_pc=RESET_PC.
- Back-to-back redirects: the last one wins; each redirect restarts the 3-cycle latency.
- Arithmetic wraps silently: fetch_pc at 2^WIDTH-4 increments to 0, and branch targets wrap the same way.
- Rst asserted mid-operation clears all state immediately, including the in-flight flag; the pending memory response is ignored.

Test Plan:
- Reset, RESET_PC=0, out_ready=1, imem returns mem[addr>>2] -> out_valid from cycle 2; out_pc = 0, 4, 8, ... one per cycle; out_pc4 = out_pc+4.
- out_ready=0 for 10 cycles with DEPTH=4 -> imem_req drops after the buffer holds 4 and nothing is in flight. Release -> 4 consecutive pops with no gap, no lost or duplicated PC.
- Branch redirect, redir_pc=0x100, mode 01, imm[15:0]=0xFFFC -> out_valid=0 in T..T+2; out_pc=0xF4 at T+3; earlier buffered entries never appear.
- Jump mode 00, redir_pc=0x3000_0010, imm=0x0000040 -> target 0x3000_0100. Register mode 10, redir_reg=0x203 -> target 0x200.
- Redirect in the cycle an imem response returns (inflight=1) -> that response is dropped; the first valid output is the target instruction.
- rst pulsed mid-stream for less than one cycle, asynchronously -> out_valid=0 immediately; after release, fetch restarts at RESET_PC.
